// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for the stage boundary.
// The EX side is the slave; the pipeline (or bench) driving ID/EX is the master.
interface execute_stage_if #(
    parameter int unsigned DW = 16
);
    logic          ex_mem_en;
    logic          ex_mem_flush;
    logic [3:0]    EX_opcode;
    logic [DW-1:0] EX_rs_reg_data;
    logic [DW-1:0] EX_rt_reg_data;
    logic [DW-1:0] EX_imm_signext;
    logic [7:0]    EX_load_byte;
    logic [DW-1:0] EX_PC_nxt;
    logic [3:0]    EX_rd_reg;
    logic [2:0]    EX_ALUOp;
    logic          EX_ALUSrc;
    logic          EX_LB_mode;
    logic          EX_LB_result_sel;
    logic          EX_PC_save;
    logic          EX_MemRead;
    logic          EX_MemWrite;
    logic          EX_DMEM_en;
    logic          EX_MemtoReg;
    logic          EX_RegWrite;
    logic          EX_Hlt;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] MEM_alu_result;
    logic [DW-1:0] MEM_store_data;
    logic [3:0]    MEM_rd_reg;
    logic          MEM_MemRead;
    logic          MEM_MemWrite;
    logic          MEM_DMEM_en;
    logic          MEM_MemtoReg;
    logic          MEM_RegWrite;
    logic          MEM_Hlt;
    logic [2:0]    flags;

    modport slave (
        input  ex_mem_en, ex_mem_flush, EX_opcode, EX_rs_reg_data, EX_rt_reg_data,
               EX_imm_signext, EX_load_byte, EX_PC_nxt, EX_rd_reg, EX_ALUOp, EX_ALUSrc,
               EX_LB_mode, EX_LB_result_sel, EX_PC_save, EX_MemRead, EX_MemWrite,
               EX_DMEM_en, EX_MemtoReg, EX_RegWrite, EX_Hlt, fwd_a_sel, fwd_b_sel, wb_data,
        output MEM_alu_result, MEM_store_data, MEM_rd_reg, MEM_MemRead, MEM_MemWrite,
               MEM_DMEM_en, MEM_MemtoReg, MEM_RegWrite, MEM_Hlt, flags
    );

    modport master (
        output ex_mem_en, ex_mem_flush, EX_opcode, EX_rs_reg_data, EX_rt_reg_data,
               EX_imm_signext, EX_load_byte, EX_PC_nxt, EX_rd_reg, EX_ALUOp, EX_ALUSrc,
               EX_LB_mode, EX_LB_result_sel, EX_PC_save, EX_MemRead, EX_MemWrite,
               EX_DMEM_en, EX_MemtoReg, EX_RegWrite, EX_Hlt, fwd_a_sel, fwd_b_sel, wb_data,
        input  MEM_alu_result, MEM_store_data, MEM_rd_reg, MEM_MemRead, MEM_MemWrite,
               MEM_DMEM_en, MEM_MemtoReg, MEM_RegWrite, MEM_Hlt, flags
    );
endinterface

// File: rtl/execute_stage.sv
// EX stage of the 16-bit pipeline: forwarding muxes, saturating ALU, LLB/LHB/PCS result select,
// Z/V/N flag register and the EX/MEM pipeline register.
module execute_stage #(
    parameter int unsigned DW = 16
) (
    input logic            clk,
    input logic            rst_n,
    execute_stage_if.slave ex
);
    localparam logic [DW-1:0] SatMax = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SatMin = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] mem_alu_result_q;
    logic [DW-1:0] mem_store_data_q;
    logic [3:0]    mem_rd_reg_q;
    logic [5:0]    mem_ctrl_q;
    logic [2:0]    flags_q;
    logic [2:0]    flags_d;
    logic          flag_we;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] op2;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] result;
    logic          alu_sat;
    logic [DW:0]   add_ext;
    logic [DW:0]   sub_ext;
    logic [9:0]    red_sum;
    logic [DW-1:0] paddsb_res;
    logic [2*DW-1:0] rot;
    logic [3:0]    amt;
    logic          upd_all;
    logic          upd_z;

    // Forwarding: MEM source is this stage's own registered result.
    always_comb begin
        case (ex.fwd_a_sel)
            2'b01:   op_a = mem_alu_result_q;
            2'b10:   op_a = ex.wb_data;
            default: op_a = ex.EX_rs_reg_data;
        endcase
        case (ex.fwd_b_sel)
            2'b01:   op_b = mem_alu_result_q;
            2'b10:   op_b = ex.wb_data;
            default: op_b = ex.EX_rt_reg_data;
        endcase
        op2 = ex.EX_ALUSrc ? ex.EX_imm_signext : op_b;
    end

    always_comb begin
        logic [4:0] nib;
        amt     = ex.EX_imm_signext[3:0];
        add_ext = {op_a[DW-1], op_a} + {op2[DW-1], op2};
        sub_ext = {op_a[DW-1], op_a} - {op2[DW-1], op2};
        red_sum = {{2{op_a[15]}}, op_a[15:8]} + {{2{op_a[7]}}, op_a[7:0]}
                + {{2{op2[15]}}, op2[15:8]} + {{2{op2[7]}}, op2[7:0]};
        rot     = {op_a, op_a} >> amt;
        paddsb_res = '0;
        for (int i = 0; i < 4; i++) begin
            nib = {op_a[4*i+3], op_a[4*i +: 4]} + {op2[4*i+3], op2[4*i +: 4]};
            // Sign of the 5-bit sum disagreeing with bit 3 means the nibble overflowed.
            if (nib[4] != nib[3]) begin
                paddsb_res[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
            end else begin
                paddsb_res[4*i +: 4] = nib[3:0];
            end
        end
    end

    always_comb begin
        alu_sat = 1'b0;
        alu_res = '0;
        unique case (ex.EX_ALUOp)
            3'b000: begin
                alu_sat = add_ext[DW] ^ add_ext[DW-1];
                alu_res = alu_sat ? (add_ext[DW] ? SatMin : SatMax) : add_ext[DW-1:0];
            end
            3'b001: begin
                alu_sat = sub_ext[DW] ^ sub_ext[DW-1];
                alu_res = alu_sat ? (sub_ext[DW] ? SatMin : SatMax) : sub_ext[DW-1:0];
            end
            3'b010: alu_res = op_a ^ op2;
            3'b011: alu_res = {{(DW-10){red_sum[9]}}, red_sum};
            3'b100: alu_res = op_a << amt;
            3'b101: alu_res = $unsigned($signed(op_a) >>> amt);
            3'b110: alu_res = rot[DW-1:0];
            3'b111: alu_res = paddsb_res;
        endcase
    end

    always_comb begin
        if (ex.EX_PC_save) begin
            result = ex.EX_PC_nxt;
        end else if (ex.EX_LB_result_sel) begin
            result = ex.EX_LB_mode ? {ex.EX_load_byte, op_b[7:0]} : {op_b[15:8], ex.EX_load_byte};
        end else begin
            result = alu_res;
        end
    end

    always_comb begin
        upd_all = 1'b0;
        upd_z   = 1'b0;
        case (ex.EX_opcode)
            4'b0000, 4'b0001:                   upd_all = 1'b1;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: upd_z   = 1'b1;
            default: ;
        endcase
        flag_we = ex.ex_mem_en & ~ex.ex_mem_flush & ex.EX_RegWrite & (upd_all | upd_z);
        flags_d = flags_q;
        flags_d[2] = (result == '0);
        if (upd_all) begin
            flags_d[1] = alu_sat;
            flags_d[0] = result[DW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (flag_we) begin
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_rd_reg_q     <= '0;
            mem_ctrl_q       <= '0;
        end else if (ex.ex_mem_flush) begin
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_rd_reg_q     <= '0;
            mem_ctrl_q       <= '0;
        end else if (ex.ex_mem_en) begin
            mem_alu_result_q <= result;
            mem_store_data_q <= op_b;
            mem_rd_reg_q     <= ex.EX_rd_reg;
            mem_ctrl_q       <= {ex.EX_MemRead, ex.EX_MemWrite, ex.EX_DMEM_en,
                                 ex.EX_MemtoReg, ex.EX_RegWrite, ex.EX_Hlt};
        end
    end

    assign ex.MEM_alu_result = mem_alu_result_q;
    assign ex.MEM_store_data = mem_store_data_q;
    assign ex.MEM_rd_reg     = mem_rd_reg_q;
    assign ex.MEM_MemRead    = mem_ctrl_q[5];
    assign ex.MEM_MemWrite   = mem_ctrl_q[4];
    assign ex.MEM_DMEM_en    = mem_ctrl_q[3];
    assign ex.MEM_MemtoReg   = mem_ctrl_q[2];
    assign ex.MEM_RegWrite   = mem_ctrl_q[1];
    assign ex.MEM_Hlt        = mem_ctrl_q[0];
    assign ex.flags          = flags_q;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed spec scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    execute_stage_if #(.DW(16)) bus ();

    execute_stage #(.DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [15:0] e_alu, e_store;
    logic [3:0]  e_rd;
    logic [5:0]  e_ctrl;
    logic [2:0]  e_flags;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int v, output logic ovf);
        ovf = (v > 32767) || (v < -32768);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] d,
                                         input logic [15:0] m, input logic [15:0] w);
        if (s == 2'b01) return m;
        if (s == 2'b10) return w;
        return d;
    endfunction

    task automatic model_reset();
        e_alu = '0; e_store = '0; e_rd = '0; e_ctrl = '0; e_flags = '0;
    endtask

    // Computes next expected state from current inputs and reference state.
    task automatic model_next(output logic [15:0] n_alu, output logic [15:0] n_store,
                              output logic [3:0] n_rd, output logic [5:0] n_ctrl,
                              output logic [2:0] n_flags);
        logic [15:0] a, b, op2, res, r;
        logic v;
        int ia, ib, s, x, y;
        byte b0, b1, b2, b3;
        a = pick(bus.fwd_a_sel, bus.EX_rs_reg_data, e_alu, bus.wb_data);
        b = pick(bus.fwd_b_sel, bus.EX_rt_reg_data, e_alu, bus.wb_data);
        op2 = bus.EX_ALUSrc ? bus.EX_imm_signext : b;
        ia = $signed(a);
        ib = $signed(op2);
        v = 1'b0;
        res = '0;
        case (bus.EX_ALUOp)
            3'd0: res = sat16(ia + ib, v);
            3'd1: res = sat16(ia - ib, v);
            3'd2: res = a ^ op2;
            3'd3: begin
                b0 = a[15:8]; b1 = a[7:0]; b2 = op2[15:8]; b3 = op2[7:0];
                s = int'(b0) + int'(b1) + int'(b2) + int'(b3);
                res = s[15:0];
            end
            3'd4: res = a << bus.EX_imm_signext[3:0];
            3'd5: begin
                s = ia >>> bus.EX_imm_signext[3:0];
                res = s[15:0];
            end
            3'd6: begin
                r = a;
                repeat (bus.EX_imm_signext[3:0]) r = {r[0], r[15:1]};
                res = r;
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    x = a[4*i +: 4];   if (x > 7) x -= 16;
                    y = op2[4*i +: 4]; if (y > 7) y -= 16;
                    s = x + y;
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    res[4*i +: 4] = s[3:0];
                end
            end
        endcase
        if (bus.EX_PC_save) res = bus.EX_PC_nxt;
        else if (bus.EX_LB_result_sel)
            res = bus.EX_LB_mode ? {bus.EX_load_byte, b[7:0]} : {b[15:8], bus.EX_load_byte};

        n_alu = e_alu; n_store = e_store; n_rd = e_rd; n_ctrl = e_ctrl; n_flags = e_flags;
        if (bus.ex_mem_flush) begin
            n_alu = '0; n_store = '0; n_rd = '0; n_ctrl = '0;
        end else if (bus.ex_mem_en) begin
            n_alu = res; n_store = b; n_rd = bus.EX_rd_reg;
            n_ctrl = {bus.EX_MemRead, bus.EX_MemWrite, bus.EX_DMEM_en, bus.EX_MemtoReg,
                      bus.EX_RegWrite, bus.EX_Hlt};
            if (bus.EX_RegWrite) begin
                if (bus.EX_opcode inside {4'd0, 4'd1})
                    n_flags = {res == 16'h0, v, res[15]};
                else if (bus.EX_opcode inside {4'd2, 4'd4, 4'd5, 4'd6})
                    n_flags[2] = (res == 16'h0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".alu"}, bus.MEM_alu_result, e_alu);
        check_eq({tag, ".store"}, bus.MEM_store_data, e_store);
        check_eq({tag, ".rd"}, bus.MEM_rd_reg, e_rd);
        check_eq({tag, ".ctrl"}, {bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_DMEM_en,
                                  bus.MEM_MemtoReg, bus.MEM_RegWrite, bus.MEM_Hlt}, e_ctrl);
        check_eq({tag, ".flags"}, bus.flags, e_flags);
    endtask

    task automatic step(input string tag);
        logic [15:0] n_alu, n_store;
        logic [3:0]  n_rd;
        logic [5:0]  n_ctrl;
        logic [2:0]  n_flags;
        model_next(n_alu, n_store, n_rd, n_ctrl, n_flags);
        @(posedge clk);
        #1;
        e_alu = n_alu; e_store = n_store; e_rd = n_rd; e_ctrl = n_ctrl; e_flags = n_flags;
        check_all(tag);
    endtask

    task automatic set_op(input logic [3:0] opc, input logic [2:0] aluop, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] imm, input logic alusrc);
        bus.ex_mem_en = 1'b1;     bus.ex_mem_flush = 1'b0;
        bus.EX_opcode = opc;      bus.EX_ALUOp = aluop;
        bus.EX_rs_reg_data = a;   bus.EX_rt_reg_data = b;
        bus.EX_imm_signext = imm; bus.EX_ALUSrc = alusrc;
        bus.EX_load_byte = 8'h00; bus.EX_PC_nxt = 16'h0000; bus.EX_rd_reg = 4'h3;
        bus.EX_LB_mode = 1'b0;    bus.EX_LB_result_sel = 1'b0; bus.EX_PC_save = 1'b0;
        bus.EX_MemRead = 1'b0;    bus.EX_MemWrite = 1'b0; bus.EX_DMEM_en = 1'b0;
        bus.EX_MemtoReg = 1'b0;   bus.EX_RegWrite = 1'b1; bus.EX_Hlt = 1'b0;
        bus.fwd_a_sel = 2'b00;    bus.fwd_b_sel = 2'b00; bus.wb_data = 16'h0000;
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] edges [6];
        edges = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h7777};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        set_op(4'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: positive saturation
        set_op(4'b0000, 3'd0, 16'h7FF0, 16'h0020, 16'h0000, 1'b0);
        step("add_sat");
        check_eq("add_sat.val", bus.MEM_alu_result, 16'h7FFF);
        check_eq("add_sat.flg", bus.flags, 3'b010);

        // 2: SUB zero then XOR (Z only)
        set_op(4'b0001, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0);
        step("sub_zero");
        check_eq("sub_zero.flg", bus.flags, 3'b100);
        set_op(4'b0010, 3'd2, 16'h00FF, 16'h0F00, 16'h0000, 1'b0);
        step("xor");
        check_eq("xor.val", bus.MEM_alu_result, 16'h0FFF);
        check_eq("xor.flg", bus.flags, 3'b000);

        // 3: PADDSB
        set_op(4'b0111, 3'd7, 16'h7171, 16'h1111, 16'h0000, 1'b0);
        step("paddsb");
        check_eq("paddsb.val", bus.MEM_alu_result, 16'h7272);

        // 4: LHB / LLB / PCS
        set_op(4'b1011, 3'd0, 16'h0000, 16'h1234, 16'h0000, 1'b0);
        bus.EX_load_byte = 8'hAB; bus.EX_LB_result_sel = 1'b1; bus.EX_LB_mode = 1'b1;
        step("lhb");
        check_eq("lhb.val", bus.MEM_alu_result, 16'hAB34);
        bus.EX_opcode = 4'b1010; bus.EX_LB_mode = 1'b0;
        step("llb");
        check_eq("llb.val", bus.MEM_alu_result, 16'h12AB);
        set_op(4'b1110, 3'd0, 16'h5555, 16'h0000, 16'h0000, 1'b0);
        bus.EX_PC_save = 1'b1; bus.EX_PC_nxt = 16'h0042;
        step("pcs");
        check_eq("pcs.val", bus.MEM_alu_result, 16'h0042);
        check_eq("pcs.flg", bus.flags, 3'b000);

        // 5: forwarding from MEM
        set_op(4'b0000, 3'd0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        step("fwd_prep");
        set_op(4'b0000, 3'd0, 16'h9999, 16'h0000, 16'h0001, 1'b1);
        bus.fwd_a_sel = 2'b01;
        step("fwd");
        check_eq("fwd.val", bus.MEM_alu_result, 16'h0011);

        // 6: stall, flush, async reset
        set_op(4'b0001, 3'd1, 16'h0003, 16'h0003, 16'h0000, 1'b0);
        bus.ex_mem_en = 1'b0;
        step("stall");
        check_eq("stall.val", bus.MEM_alu_result, 16'h0011);
        check_eq("stall.flg", bus.flags, 3'b000);
        set_op(4'b0001, 3'd1, 16'h0003, 16'h0003, 16'h0000, 1'b0);
        bus.ex_mem_flush = 1'b1; bus.EX_MemRead = 1'b1;
        step("flush");
        check_eq("flush.val", bus.MEM_alu_result, 16'h0000);
        check_eq("flush.rw", bus.MEM_RegWrite, 1'b0);
        check_eq("flush.flg", bus.flags, 3'b000);
        set_op(4'b0001, 3'd1, 16'h8000, 16'h0001, 16'h0000, 1'b0);
        step("neg_sat");
        check_eq("neg_sat.val", bus.MEM_alu_result, 16'h8000);
        check_eq("neg_sat.flg", bus.flags, 3'b011);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            set_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rand_data(),
                   rand_data(), rand_data(), 1'($urandom_range(0, 1)));
            bus.ex_mem_en = ($urandom_range(0, 7) != 0);
            bus.ex_mem_flush = ($urandom_range(0, 15) == 0);
            bus.fwd_a_sel = 2'($urandom_range(0, 3));
            bus.fwd_b_sel = 2'($urandom_range(0, 3));
            bus.wb_data = rand_data();
            bus.EX_load_byte = 8'($urandom);
            bus.EX_PC_nxt = 16'($urandom);
            bus.EX_rd_reg = 4'($urandom);
            bus.EX_RegWrite = ($urandom_range(0, 3) != 0);
            bus.EX_LB_result_sel = ($urandom_range(0, 7) == 0);
            bus.EX_LB_mode = 1'($urandom_range(0, 1));
            bus.EX_PC_save = ($urandom_range(0, 11) == 0);
            {bus.EX_MemRead, bus.EX_MemWrite, bus.EX_DMEM_en, bus.EX_MemtoReg, bus.EX_Hlt} =
                5'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
